mux_tree8: RTL and testbench
============================

MUX_TREE8 -- requirements
Module: mux_tree8

Interface
REQ-001 Parameter WIDTH, default 1, is the bit width of each data lane.
REQ-002 clk  input  1  rising-edge clock for the output register.
REQ-003 reset  input  1  asynchronous, active-high reset of the output register.
REQ-004 sel  input  3  lane select, binary, 0..7.
REQ-005 in  input  8*WIDTH  eight packed data lanes; lane i = in[i*WIDTH +: WIDTH]; with WIDTH=1, lane i = in[i].
REQ-006 en  input  1  capture enable for the registered output.
REQ-007 out  output  WIDTH  combinational selected lane.
REQ-008 out_q  output  WIDTH  registered copy of out.
REQ-009 valid_q  output  1  high when out_q holds a value captured on the previous enabled edge.

Function
REQ-010 out SHALL equal lane[sel] combinationally, with no clock dependence and zero cycle latency.
REQ-011 Selection SHALL be bit-exact for all 8 sel codes; e.g. sel=3'b110 picks in[6] (WIDTH=1).
REQ-012 Lower stage: lanes 0..3 SHALL be selected by sel[1:0] into lower_out; lanes 4..7 SHALL be selected by sel[1:0] into upper_out.
REQ-013 Final stage SHALL output lower_out when sel[2]=0 and upper_out when sel[2]=1.
REQ-014 On a rising clk with en=1, out_q SHALL load out and valid_q SHALL become 1 (1-cycle latency).
REQ-015 On a rising clk with en=0, out_q SHALL hold its value and valid_q SHALL become 0.
REQ-016 sel or in changing between edges SHALL affect out immediately and out_q only at the next enabled edge.
REQ-017 If sel contains X/Z, the value of out is unspecified; no other behaviour is required.
REQ-018 The block SHALL contain no latches; the only state is out_q and valid_q.

Reset
REQ-019 While reset=1, out_q SHALL be 0 and valid_q SHALL be 0, independent of clk.
REQ-020 Asserting reset mid-operation SHALL clear out_q and valid_q immediately.
REQ-021 reset SHALL NOT affect the combinational out.
REQ-022 The first enabled edge after reset deasserts SHALL capture normally.

Structure
REQ-023 Leaf sub-module mux2_1 SHALL have ports sel (1), input_a (selected when sel=0), input_b (selected when sel=1), and out (1-bit).
REQ-024 Sub-module mux4_1 SHALL have ports sel (2), in (4), and out (1).
REQ-025 mux4_1 SHALL be built from three mux2_1 instances, in[sel] selected.
REQ-026 mux_tree8 SHALL use, per bit of WIDTH, two mux4_1 instances (lower_mux, upper_mux) and one mux2_1 instance (final_mux), generated over WIDTH.
REQ-027 Constants NUM_IN=8 and SEL_W=3 SHALL live in shared package mux_pkg; no typedefs are needed.

Verification
REQ-028 sel=0, in=8'h00 -> out=0; after an enabled edge, out_q=0 and valid_q=1.
REQ-029 sel=0, in=8'h01 -> out=1.
REQ-030 sel=3'b010, in=8'h01 -> out=0.
REQ-031 sel=3'b110, in=8'h75 -> out=1; also sweep sel 0..7 with in=8'h75 -> out sequence 1,0,1,0,1,1,1,0.
REQ-032 mux4_1 standalone: for sel 0..3 with in=4'b1010 -> out sequence 0,1,0,1; mux2_1: sel=1, input_a=0, input_b=1 -> out=1.
REQ-033 Capture out_q=1, then assert reset asynchronously between edges -> out_q=0 and valid_q=0 immediately; en=0 edge -> valid_q=0 and out_q held.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 8-way mux tree.
package mux_pkg;

  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

endpackage : mux_pkg

// File: rtl/mux2_1.sv
// Leaf 2:1 mux: input_a when sel=0, input_b when sel=1.
module mux2_1 (
  input  logic sel,
  input  logic input_a,
  input  logic input_b,
  output logic out
);

  assign out = sel ? input_b : input_a;

endmodule : mux2_1

// File: rtl/mux4_1.sv
// 4:1 mux built as a two-level tree of 2:1 muxes; out = in[sel].
module mux4_1 (
  input  logic [1:0] sel,
  input  logic [3:0] in,
  output logic       out
);

  logic pair_lo;
  logic pair_hi;

  // sel[0] picks within each pair, sel[1] picks between the pairs.
  mux2_1 mux_lo (
    .sel     (sel[0]),
    .input_a (in[0]),
    .input_b (in[1]),
    .out     (pair_lo)
  );

  mux2_1 mux_hi (
    .sel     (sel[0]),
    .input_a (in[2]),
    .input_b (in[3]),
    .out     (pair_hi)
  );

  mux2_1 mux_out (
    .sel     (sel[1]),
    .input_a (pair_lo),
    .input_b (pair_hi),
    .out     (out)
  );

endmodule : mux4_1

// File: rtl/mux_tree8.sv
// 8-lane mux tree with a combinational output and an enabled output register.
// Lane i occupies in[i*WIDTH +: WIDTH]; the tree is replicated per bit.
module mux_tree8
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic                    en,
  output logic [WIDTH-1:0]        out,
  output logic [WIDTH-1:0]        out_q,
  output logic                    valid_q
);

  logic [WIDTH-1:0] lower_out;
  logic [WIDTH-1:0] upper_out;
  logic [WIDTH-1:0] out_d;

  // Per bit: lanes 0..3 and 4..7 reduced by sel[1:0], then sel[2] picks the half.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [3:0] lo_lanes;
    logic [3:0] hi_lanes;

    assign lo_lanes = {in[3*WIDTH+b], in[2*WIDTH+b], in[1*WIDTH+b], in[0*WIDTH+b]};
    assign hi_lanes = {in[7*WIDTH+b], in[6*WIDTH+b], in[5*WIDTH+b], in[4*WIDTH+b]};

    mux4_1 lower_mux (
      .sel (sel[1:0]),
      .in  (lo_lanes),
      .out (lower_out[b])
    );

    mux4_1 upper_mux (
      .sel (sel[1:0]),
      .in  (hi_lanes),
      .out (upper_out[b])
    );

    mux2_1 final_mux (
      .sel     (sel[SEL_W-1]),
      .input_a (lower_out[b]),
      .input_b (upper_out[b]),
      .out     (out[b])
    );
  end

  assign out_d = out;

  // Output register: load on enabled edges, valid_q marks whether the last edge loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        out_q <= out_d;
      end
    end
  end

endmodule : mux_tree8

// File: tb/tb_mux_tree8.sv
// Self-checking bench for mux_tree8 (WIDTH=1 and WIDTH=3) and its leaf muxes.
module tb_mux_tree8;

  typedef struct {
    logic q;
    logic v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  sel = '0;
  logic [7:0]  din = '0;
  logic        en = 1'b0;
  logic        out;
  logic        out_q;
  logic        valid_q;

  logic [2:0]  sel3 = '0;
  logic [23:0] in3 = '0;
  logic        en3 = 1'b0;
  logic [2:0]  out3;
  logic [2:0]  out_q3;
  logic        valid_q3;

  logic [1:0]  m4_sel = '0;
  logic [3:0]  m4_in = '0;
  logic        m4_out;
  logic        m2_sel = 1'b0;
  logic        m2_a = 1'b0;
  logic        m2_b = 1'b0;
  logic        m2_out;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e;
  logic model_q = 1'b0;
  logic model_v = 1'b0;

  mux_tree8 #(.WIDTH(1)) dut (
    .clk(clk), .reset(reset), .sel(sel), .in(din), .en(en),
    .out(out), .out_q(out_q), .valid_q(valid_q)
  );

  mux_tree8 #(.WIDTH(3)) dut_w (
    .clk(clk), .reset(reset), .sel(sel3), .in(in3), .en(en3),
    .out(out3), .out_q(out_q3), .valid_q(valid_q3)
  );

  mux4_1 u_m4 (.sel(m4_sel), .in(m4_in), .out(m4_out));
  mux2_1 u_m2 (.sel(m2_sel), .input_a(m2_a), .input_b(m2_b), .out(m2_out));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_mux(input logic [2:0] s, input logic [7:0] d);
    return d[s];
  endfunction

  function automatic logic [2:0] ref_mux3(input logic [2:0] s, input logic [23:0] d);
    return d[int'(s)*3 +: 3];
  endfunction

  // Record what the register should hold after the coming edge.
  task automatic push_exp();
    if (en) model_q = ref_mux(sel, din);
    model_v = en;
    sb.push_back('{q: model_q, v: model_v});
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; sel = 3'd0; din = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_q !== 1'b0) begin errors++; $display("FAIL reset_out_q: got %b expected 0", out_q); end
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid_q: got %b expected 0", valid_q); end
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL reset_comb_out: got %b expected 1", out); end
    reset = 1'b0; en = 1'b0;
    model_q = 1'b0; model_v = 1'b0;
  endtask

  task automatic test_basic();
    sel = 3'd0; din = 8'h00; en = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL basic_00: got %b expected 0", out); end
    push_exp();
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q || valid_q !== e.v)
      begin errors++; $display("FAIL basic_capture: got q=%b v=%b expected q=%b v=%b", out_q, valid_q, e.q, e.v); end
    din = 8'h01; #1;
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL basic_sel0_in01: got %b expected 1", out); end
    sel = 3'b010; #1;
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL basic_sel2_in01: got %b expected 0", out); end
    sel = 3'b110; din = 8'h75; #1;
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL basic_sel6_in75: got %b expected 1", out); end
  endtask

  task automatic test_sweep();
    logic [7:0] tab;
    tab = 8'b0111_0101; // expected out for sel 7..0: 0,1,1,1,0,1,0,1
    din = 8'h75; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); #1;
      checks++;
      if (out !== tab[i]) begin errors++; $display("FAIL sweep_sel%0d: got %b expected %b", i, out, tab[i]); end
      push_exp();
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_q !== e.q || valid_q !== e.v)
        begin errors++; $display("FAIL sweep_reg_sel%0d: got q=%b v=%b expected q=%b v=%b", i, out_q, valid_q, e.q, e.v); end
    end
  endtask

  task automatic test_hold();
    sel = 3'd0; din = 8'h01; en = 1'b1;
    push_exp();
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q || valid_q !== e.v)
      begin errors++; $display("FAIL hold_load: got q=%b v=%b expected q=%b v=%b", out_q, valid_q, e.q, e.v); end
    en = 1'b0; din = 8'h00; #1;
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL hold_comb_now: got %b expected 0", out); end
    checks++;
    if (out_q !== 1'b1) begin errors++; $display("FAIL hold_between_edges: got %b expected 1", out_q); end
    push_exp();
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q || valid_q !== e.v)
      begin errors++; $display("FAIL hold_en0: got q=%b v=%b expected q=%b v=%b", out_q, valid_q, e.q, e.v); end
  endtask

  task automatic test_async_reset();
    sel = 3'd0; din = 8'h01; en = 1'b1;
    push_exp();
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q || valid_q !== e.v)
      begin errors++; $display("FAIL areset_preload: got q=%b v=%b expected q=%b v=%b", out_q, valid_q, e.q, e.v); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (out_q !== 1'b0 || valid_q !== 1'b0)
      begin errors++; $display("FAIL areset_immediate: got q=%b v=%b expected q=0 v=0", out_q, valid_q); end
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL areset_comb_out: got %b expected 1", out); end
    #1 reset = 1'b0;
    model_q = 1'b0; model_v = 1'b0;
    en = 1'b0;
    push_exp();
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q || valid_q !== e.v)
      begin errors++; $display("FAIL areset_en0: got q=%b v=%b expected q=%b v=%b", out_q, valid_q, e.q, e.v); end
    en = 1'b1;
    push_exp();
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q || valid_q !== e.v)
      begin errors++; $display("FAIL areset_first_capture: got q=%b v=%b expected q=%b v=%b", out_q, valid_q, e.q, e.v); end
  endtask

  task automatic test_submodules();
    logic [3:0] exp4;
    exp4 = 4'b1010;
    m4_in = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      m4_sel = 2'(i); #1;
      checks++;
      if (m4_out !== exp4[i]) begin errors++; $display("FAIL mux4_sel%0d: got %b expected %b", i, m4_out, exp4[i]); end
    end
    m2_sel = 1'b1; m2_a = 1'b0; m2_b = 1'b1; #1;
    checks++;
    if (m2_out !== 1'b1) begin errors++; $display("FAIL mux2_sel1: got %b expected 1", m2_out); end
    m2_sel = 1'b0; #1;
    checks++;
    if (m2_out !== 1'b0) begin errors++; $display("FAIL mux2_sel0: got %b expected 0", m2_out); end
  endtask

  task automatic test_wide();
    logic [2:0] exp3;
    for (int i = 0; i < 12; i++) begin
      sel3 = 3'($urandom_range(0, 7));
      in3 = 24'($urandom);
      #1;
      exp3 = ref_mux3(sel3, in3);
      checks++;
      if (out3 !== exp3) begin errors++; $display("FAIL wide_comb_%0d: got %h expected %h", i, out3, exp3); end
    end
    en3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_q3 !== exp3 || valid_q3 !== 1'b1)
      begin errors++; $display("FAIL wide_capture: got q=%h v=%b expected q=%h v=1", out_q3, valid_q3, exp3); end
    en3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_o;
    for (int i = 0; i < 40; i++) begin
      sel = 3'($urandom_range(0, 7));
      din = 8'($urandom);
      en = 1'($urandom_range(0, 1));
      #1;
      exp_o = ref_mux(sel, din);
      checks++;
      if (out !== exp_o) begin errors++; $display("FAIL b2b_comb_%0d: got %b expected %b", i, out, exp_o); end
      push_exp();
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_q !== e.q || valid_q !== e.v)
        begin errors++; $display("FAIL b2b_reg_%0d: got q=%b v=%b expected q=%b v=%b", i, out_q, valid_q, e.q, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_hold();
    test_async_reset();
    test_submodules();
    test_wide();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_tree8
